// File: rtl/ifetch_ctrl_if.sv
// Instruction-memory bus between the fetch controller (master) and the
// instruction memory (slave).
//
// Handshake: a request transfers on a rising edge where imem_req=1 and
// imem_ready=1; imem_req and imem_addr stay stable until then. The memory
// answers every accepted request with exactly one imem_rvalid pulse carrying
// imem_rdata, no earlier than the cycle after acceptance.
interface ifetch_ctrl_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ready,
      input  imem_rvalid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ready,
      output imem_rvalid,
      output imem_rdata
   );
endinterface

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller between the PC register and decode.
// Issues one request at a time to a variable-latency instruction memory,
// holds the returned word until decode acknowledges it, and pulses pc_ena
// to advance or redirect the PC.
//
// Optional feature: define IFETCH_TIMEOUT_EN to bound the WAIT state; after
// TIMEOUT_CYCLES cycles without read data the controller raises fetch_fault.
//
// dbg_state encoding: 0 IDLE, 1 REQ, 2 WAIT, 3 HOLD, 4 FAULT.
module ifetch_ctrl #(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int TMO_W          = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [31:0]          pc_in,
   output logic                 pc_ena,
   input  logic                 flush,
   ifetch_ctrl_if.master        imem,
   output logic [31:0]          instr_out,
   output logic                 instr_valid,
   input  logic                 instr_ack,
   output logic                 fetch_fault,
   output logic [2:0]           dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_WAIT  = 3'd2,
      S_HOLD  = 3'd3,
      S_FAULT = 3'd4
   } state_t;

   state_t state;
   // Set when a flush hits an outstanding request: its data must be swallowed.
   logic   drop;

   // The timeout counter must be able to reach TIMEOUT_CYCLES-1.
   if ((2 ** TMO_W) <= TIMEOUT_CYCLES) begin : g_cfg_check
      $error("ifetch_ctrl: TMO_W too narrow for TIMEOUT_CYCLES");
   end

`ifdef IFETCH_TIMEOUT_EN
   logic [TMO_W-1:0] tmo_cnt;
   logic             tmo_hit;

   // Last WAIT cycle allowed before the fetch is declared lost.
   assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`endif

   assign dbg_state = state;

   // Fetch FSM; every output is a register updated here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= S_IDLE;
         drop           <= 1'b0;
         pc_ena         <= 1'b0;
         imem.imem_req  <= 1'b0;
         imem.imem_addr <= 32'h0;
         instr_out      <= 32'h0;
         instr_valid    <= 1'b0;
         fetch_fault    <= 1'b0;
`ifdef IFETCH_TIMEOUT_EN
         tmo_cnt        <= '0;
`endif
      end else begin
         pc_ena <= 1'b0;
         case (state)
            S_IDLE: begin
               if (flush) begin
                  // Toggling keeps pc_ena from ever being high two cycles running.
                  pc_ena <= !pc_ena;
               end else begin
                  // pc_in has settled a full cycle; latch it as the fetch address.
                  state          <= S_REQ;
                  imem.imem_req  <= (pc_in[1:0] == 2'b00);
                  imem.imem_addr <= pc_in;
               end
            end
            S_REQ: begin
               if (imem.imem_req && imem.imem_ready) begin
                  // Accepted: a flush now must wait for the data to drain.
                  imem.imem_req <= 1'b0;
                  drop          <= flush;
                  state         <= S_WAIT;
`ifdef IFETCH_TIMEOUT_EN
                  tmo_cnt       <= '0;
`endif
               end else if (flush) begin
                  imem.imem_req <= 1'b0;
                  pc_ena        <= 1'b1;
                  state         <= S_IDLE;
               end else if (imem.imem_addr[1:0] != 2'b00) begin
                  fetch_fault <= 1'b1;
                  state       <= S_FAULT;
               end
            end
            S_WAIT: begin
               if (imem.imem_rvalid) begin
                  if (drop || flush) begin
                     drop   <= 1'b0;
                     pc_ena <= 1'b1;
                     state  <= S_IDLE;
                  end else begin
                     instr_out   <= imem.imem_rdata;
                     instr_valid <= 1'b1;
                     state       <= S_HOLD;
                  end
               end
`ifdef IFETCH_TIMEOUT_EN
               else if (tmo_hit) begin
                  drop        <= 1'b0;
                  fetch_fault <= 1'b1;
                  state       <= S_FAULT;
               end
`endif
               else begin
                  if (flush) begin
                     drop <= 1'b1;
                  end
`ifdef IFETCH_TIMEOUT_EN
                  tmo_cnt <= tmo_cnt + 1'b1;
`endif
               end
            end
            S_HOLD: begin
               // flush and ack together still produce a single pc_ena pulse.
               if (flush || instr_ack) begin
                  instr_valid <= 1'b0;
                  pc_ena      <= 1'b1;
                  state       <= S_IDLE;
               end
            end
            S_FAULT: begin
               if (flush) begin
                  fetch_fault <= 1'b0;
                  pc_ena      <= 1'b1;
                  state       <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed testbench for ifetch_ctrl. Inputs change and outputs are sampled
// on the falling clock edge; the bench plays the PC register by updating
// pc_in in the cycle where pc_ena is high.
module tb_ifetch_ctrl;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_REQ   = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_HOLD  = 3'd3;
   localparam logic [2:0] S_FAULT = 3'd4;

   // Clock and reset
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] pc_in;
   logic        pc_ena;
   logic        flush;
   logic [31:0] instr_out;
   logic        instr_valid;
   logic        instr_ack;
   logic        fetch_fault;
   logic [2:0]  dbg_state;
   int          cyc = 0;
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   ifetch_ctrl_if bus ();

   ifetch_ctrl #(
      .TIMEOUT_CYCLES(64),
      .TMO_W(8)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .pc_in(pc_in),
      .pc_ena(pc_ena),
      .flush(flush),
      .imem(bus),
      .instr_out(instr_out),
      .instr_valid(instr_valid),
      .instr_ack(instr_ack),
      .fetch_fault(fetch_fault),
      .dbg_state(dbg_state)
   );

   // Driver tasks
   task automatic step();
      @(negedge clk);
   endtask

   // From REQ with an aligned address: zero-wait accept, one-cycle data,
   // immediate ack; returns at the falling edge after the next REQ entry.
   task automatic finish_fetch(input logic [31:0] data, input logic [31:0] next_pc);
      bus.imem_ready = 1'b1;
      step();
      bus.imem_ready = 1'b0;
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata = data;
      step();
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata = 32'h0;
      instr_ack = 1'b1;
      step();
      instr_ack = 1'b0;
      pc_in = next_pc;
      step();
   endtask

   // Tests
   task automatic test_reset();
      rst_n = 1'b0;
      flush = 1'b0;
      instr_ack = 1'b0;
      pc_in = 32'h0040_0000;
      bus.imem_ready = 1'b0;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata = 32'h0;
      step();
      step();
      checks++; if (dbg_state !== S_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, S_IDLE); end
      checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", bus.imem_req); end
      checks++; if (bus.imem_addr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", bus.imem_addr); end
      checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
      checks++; if (instr_out !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h exp=0", instr_out); end
      checks++; if (pc_ena !== 1'b0) begin failures++; $display("FAIL reset_pc_ena got=%b exp=0", pc_ena); end
      checks++; if (fetch_fault !== 1'b0) begin failures++; $display("FAIL reset_fault got=%b exp=0", fetch_fault); end
   endtask

   task automatic test_basic_fetch();
      int c0;
      rst_n = 1'b1;
      step();
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0040_0000) begin failures++; $display("FAIL basic_req req=%b addr=%h exp req=1 addr=00400000", bus.imem_req, bus.imem_addr); end
      c0 = cyc;
      bus.imem_ready = 1'b1;
      step();
      checks++; if (bus.imem_req !== 1'b0 || dbg_state !== S_WAIT) begin failures++; $display("FAIL basic_wait req=%b state=%0d exp req=0 state=%0d", bus.imem_req, dbg_state, S_WAIT); end
      bus.imem_ready = 1'b0;
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata = 32'h2008_0005;
      step();
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata = 32'h0;
      checks++; if (instr_valid !== 1'b1 || instr_out !== 32'h2008_0005) begin failures++; $display("FAIL basic_instr valid=%b instr=%h exp valid=1 instr=20080005", instr_valid, instr_out); end
      instr_ack = 1'b1;
      step();
      instr_ack = 1'b0;
      checks++; if (pc_ena !== 1'b1 || instr_valid !== 1'b0) begin failures++; $display("FAIL basic_ack pc_ena=%b valid=%b exp pc_ena=1 valid=0", pc_ena, instr_valid); end
      pc_in = 32'h0040_0004;
      step();
      checks++; if (pc_ena !== 1'b0) begin failures++; $display("FAIL basic_pulse_width pc_ena=%b exp=0", pc_ena); end
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0040_0004) begin failures++; $display("FAIL basic_next_req req=%b addr=%h exp req=1 addr=00400004", bus.imem_req, bus.imem_addr); end
      checks++; if (cyc - c0 !== 4) begin failures++; $display("FAIL basic_spacing got=%0d exp=4", cyc - c0); end
   endtask

   task automatic test_ready_stall();
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0040_0004 || pc_ena !== 1'b0) begin failures++; $display("FAIL stall_hold cycle=%0d req=%b addr=%h pc_ena=%b exp req=1 addr=00400004 pc_ena=0", i, bus.imem_req, bus.imem_addr, pc_ena); end
      end
      bus.imem_ready = 1'b1;
      step();
      bus.imem_ready = 1'b0;
      step();
      checks++; if (dbg_state !== S_WAIT || instr_valid !== 1'b0) begin failures++; $display("FAIL stall_wait state=%0d valid=%b exp state=%0d valid=0", dbg_state, instr_valid, S_WAIT); end
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata = 32'h8C09_0000;
      step();
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata = 32'h0;
      step();
      checks++; if (instr_valid !== 1'b1 || instr_out !== 32'h8C09_0000 || dbg_state !== S_HOLD) begin failures++; $display("FAIL stall_hold_instr valid=%b instr=%h state=%0d exp valid=1 instr=8c090000 state=%0d", instr_valid, instr_out, dbg_state, S_HOLD); end
      instr_ack = 1'b1;
      step();
      instr_ack = 1'b0;
      checks++; if (pc_ena !== 1'b1) begin failures++; $display("FAIL stall_pc_ena got=%b exp=1", pc_ena); end
      pc_in = 32'h0040_0008;
      step();
   endtask

   task automatic test_flush_wait();
      bus.imem_ready = 1'b1;
      step();
      bus.imem_ready = 1'b0;
      flush = 1'b1;
      pc_in = 32'h0040_0008;
      step();
      flush = 1'b0;
      checks++; if (dbg_state !== S_WAIT || pc_ena !== 1'b0) begin failures++; $display("FAIL flush_wait_stay state=%0d pc_ena=%b exp state=%0d pc_ena=0", dbg_state, pc_ena, S_WAIT); end
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata = 32'hDEAD_BEEF;
      step();
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata = 32'h0;
      checks++; if (instr_valid !== 1'b0 || pc_ena !== 1'b1 || dbg_state !== S_IDLE) begin failures++; $display("FAIL flush_wait_drop valid=%b pc_ena=%b state=%0d exp valid=0 pc_ena=1 state=%0d", instr_valid, pc_ena, dbg_state, S_IDLE); end
      pc_in = 32'h0040_0100;
      step();
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0040_0100 || instr_valid !== 1'b0) begin failures++; $display("FAIL flush_wait_target req=%b addr=%h valid=%b exp req=1 addr=00400100 valid=0", bus.imem_req, bus.imem_addr, instr_valid); end
      finish_fetch(32'h1111_1111, 32'h0040_0104);
   endtask

   task automatic test_flush_req();
      flush = 1'b1;
      step();
      flush = 1'b0;
      checks++; if (bus.imem_req !== 1'b0 || pc_ena !== 1'b1 || dbg_state !== S_IDLE) begin failures++; $display("FAIL flush_req req=%b pc_ena=%b state=%0d exp req=0 pc_ena=1 state=%0d", bus.imem_req, pc_ena, dbg_state, S_IDLE); end
      pc_in = 32'h0040_0300;
      step();
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0040_0300) begin failures++; $display("FAIL flush_req_target req=%b addr=%h exp req=1 addr=00400300", bus.imem_req, bus.imem_addr); end
   endtask

   task automatic test_flush_hold_ack();
      bus.imem_ready = 1'b1;
      step();
      bus.imem_ready = 1'b0;
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata = 32'h2222_2222;
      step();
      bus.imem_rvalid = 1'b0;
      flush = 1'b1;
      instr_ack = 1'b1;
      step();
      flush = 1'b0;
      instr_ack = 1'b0;
      checks++; if (pc_ena !== 1'b1 || instr_valid !== 1'b0) begin failures++; $display("FAIL flush_hold pc_ena=%b valid=%b exp pc_ena=1 valid=0", pc_ena, instr_valid); end
      pc_in = 32'h0040_0400;
      step();
      checks++; if (pc_ena !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0040_0400) begin failures++; $display("FAIL flush_hold_single pc_ena=%b req=%b addr=%h exp pc_ena=0 req=1 addr=00400400", pc_ena, bus.imem_req, bus.imem_addr); end
   endtask

   task automatic test_misaligned();
      finish_fetch(32'h3333_3333, 32'h0040_0002);
      checks++; if (bus.imem_req !== 1'b0 || dbg_state !== S_REQ) begin failures++; $display("FAIL misalign_noreq req=%b state=%0d exp req=0 state=%0d", bus.imem_req, dbg_state, S_REQ); end
      step();
      checks++; if (fetch_fault !== 1'b1 || dbg_state !== S_FAULT || bus.imem_req !== 1'b0) begin failures++; $display("FAIL misalign_fault fault=%b state=%0d req=%b exp fault=1 state=%0d req=0", fetch_fault, dbg_state, bus.imem_req, S_FAULT); end
      repeat (3) step();
      checks++; if (fetch_fault !== 1'b1 || instr_valid !== 1'b0) begin failures++; $display("FAIL misalign_sticky fault=%b valid=%b exp fault=1 valid=0", fetch_fault, instr_valid); end
      flush = 1'b1;
      step();
      flush = 1'b0;
      checks++; if (fetch_fault !== 1'b0 || pc_ena !== 1'b1) begin failures++; $display("FAIL misalign_clear fault=%b pc_ena=%b exp fault=0 pc_ena=1", fetch_fault, pc_ena); end
      pc_in = 32'h0040_0500;
      step();
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0040_0500) begin failures++; $display("FAIL misalign_resume req=%b addr=%h exp req=1 addr=00400500", bus.imem_req, bus.imem_addr); end
   endtask

   task automatic test_reset_hold();
      bus.imem_ready = 1'b1;
      step();
      bus.imem_ready = 1'b0;
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata = 32'h4444_4444;
      step();
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata = 32'h0;
      checks++; if (instr_valid !== 1'b1 || instr_out !== 32'h4444_4444) begin failures++; $display("FAIL rsthold_pre valid=%b instr=%h exp valid=1 instr=44444444", instr_valid, instr_out); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (instr_valid !== 1'b0 || instr_out !== 32'h0 || pc_ena !== 1'b0 || dbg_state !== S_IDLE) begin failures++; $display("FAIL rsthold_async valid=%b instr=%h pc_ena=%b state=%0d exp all 0", instr_valid, instr_out, pc_ena, dbg_state); end
      step();
      rst_n = 1'b1;
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata = 32'hBAD0_BAD0;
      step();
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata = 32'h0;
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0040_0500 || instr_valid !== 1'b0) begin failures++; $display("FAIL rsthold_fresh req=%b addr=%h valid=%b exp req=1 addr=00400500 valid=0", bus.imem_req, bus.imem_addr, instr_valid); end
      bus.imem_ready = 1'b1;
      step();
      bus.imem_ready = 1'b0;
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata = 32'h5555_5555;
      step();
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata = 32'h0;
      checks++; if (instr_valid !== 1'b1 || instr_out !== 32'h5555_5555) begin failures++; $display("FAIL rsthold_refetch valid=%b instr=%h exp valid=1 instr=55555555", instr_valid, instr_out); end
      instr_ack = 1'b1;
      step();
      instr_ack = 1'b0;
      pc_in = 32'h0040_0600;
      step();
   endtask

   task automatic test_wait_bound();
      bus.imem_ready = 1'b1;
      step();
      bus.imem_ready = 1'b0;
`ifdef IFETCH_TIMEOUT_EN
      repeat (63) step();
      checks++; if (fetch_fault !== 1'b0 || dbg_state !== S_WAIT) begin failures++; $display("FAIL tmo_early fault=%b state=%0d exp fault=0 state=%0d", fetch_fault, dbg_state, S_WAIT); end
      step();
      checks++; if (fetch_fault !== 1'b1 || dbg_state !== S_FAULT) begin failures++; $display("FAIL tmo_fire fault=%b state=%0d exp fault=1 state=%0d", fetch_fault, dbg_state, S_FAULT); end
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata = 32'h6666_6666;
      step();
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata = 32'h0;
      checks++; if (instr_valid !== 1'b0 || dbg_state !== S_FAULT) begin failures++; $display("FAIL tmo_late valid=%b state=%0d exp valid=0 state=%0d", instr_valid, dbg_state, S_FAULT); end
      flush = 1'b1;
      step();
      flush = 1'b0;
      checks++; if (fetch_fault !== 1'b0 || pc_ena !== 1'b1) begin failures++; $display("FAIL tmo_clear fault=%b pc_ena=%b exp fault=0 pc_ena=1", fetch_fault, pc_ena); end
`else
      repeat (200) step();
      checks++; if (fetch_fault !== 1'b0 || dbg_state !== S_WAIT) begin failures++; $display("FAIL notmo_wait fault=%b state=%0d exp fault=0 state=%0d", fetch_fault, dbg_state, S_WAIT); end
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata = 32'h6666_6666;
      step();
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata = 32'h0;
      checks++; if (instr_valid !== 1'b1 || instr_out !== 32'h6666_6666) begin failures++; $display("FAIL notmo_data valid=%b instr=%h exp valid=1 instr=66666666", instr_valid, instr_out); end
      instr_ack = 1'b1;
      step();
      instr_ack = 1'b0;
      checks++; if (pc_ena !== 1'b1) begin failures++; $display("FAIL notmo_pc_ena got=%b exp=1", pc_ena); end
`endif
   endtask

   // Run-away guard
   initial begin
      #200000;
      $display("FAIL watchdog time limit reached checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   // Sequencer and final report
   initial begin
      test_reset();
      test_basic_fetch();
      test_ready_stall();
      test_flush_wait();
      test_flush_req();
      test_flush_hold_ack();
      test_misaligned();
      test_reset_hold();
      test_wait_bound();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ifetch_ctrl.md
Name: ifetch_ctrl

Overview:
- Instruction-fetch controller placed directly downstream of the PC register.
- Takes the registered PC, runs a request/response handshake with the instruction memory, and holds the fetched word until decode accepts it.
- Drives the PC register's enable so the PC advances only after an instruction is consumed or a redirect occurs.
- Converts the CPU from an ideal single-cycle memory to a memory with variable latency.

Parameters:
- TIMEOUT_CYCLES, 64: maximum cycles in WAIT before a fetch fault is raised (used only with IFETCH_TIMEOUT_EN).
- TMO_W, 8: width of the timeout counter; must satisfy 2^TMO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock; all state in this block updates on the rising edge.
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low.
- pc_in  in  32  current PC, from the PC register output.
- pc_ena  out  1  enable to the PC register; one-cycle pulse that advances or redirects the PC.
- flush  in  1  redirect from branch/jump resolution; the PC register loads the target when pc_ena pulses.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch address.
- imem_ready  in  1  memory accepts the request (handshake completes when imem_req=1 and imem_ready=1).
- imem_rvalid  in  1  read data valid; one pulse per accepted request.
- imem_rdata  in  32  instruction word.
- instr_out  out  32  held instruction to decode.
- instr_valid  out  1  instr_out is valid.
- instr_ack  in  1  decode consumes instr_out (counts only when instr_valid=1).
- fetch_fault  out  1  sticky fault: misaligned PC or timeout.

Behaviour:
- Reset values: all outputs 0; state IDLE; timeout counter 0. Reset mid-transaction abandons it; a late imem_rvalid after reset is ignored because the state is not WAIT.
- IDLE: next cycle goes to REQ. This gives pcreg, which updates on the negative edge, one full cycle to settle.
- REQ:
  - If pc_in[1:0]!=0: go to FAULT; fetch_fault=1; no request issued.
  - Otherwise: imem_req=1, imem_addr=pc_in (registered on entry, held stable until handshake).
  - On imem_ready: go to WAIT, drop imem_req.
- WAIT:
  - On imem_rvalid: instr_out<=imem_rdata, instr_valid<=1, go to HOLD.
  - rvalid arriving in the same cycle as ready is illegal; the memory returns data at least one cycle after accept.
- HOLD:
  - instr_valid stays 1; instr_out is stable.
  - On instr_ack: instr_valid<=0, pc_ena=1 for exactly one cycle, go to IDLE.
  - Result: minimum 4 cycles per instruction with zero-wait memory (REQ, WAIT, HOLD, IDLE).
- FAULT: stays until flush or reset; fetch_fault stays set; instr_valid=0.
- flush (highest priority, any state):
  - REQ with handshake not yet complete: withdraw imem_req, pulse pc_ena, go to IDLE.
  - REQ with imem_ready in the same cycle: the request is accepted, so treat it as the WAIT case.
  - WAIT: set internal drop flag; stay in WAIT until imem_rvalid, discard the data, then pulse pc_ena and go to IDLE. No instr_valid is produced.
  - HOLD: instr_valid<=0 without ack; pulse pc_ena; go to IDLE. flush together with instr_ack is treated as flush (single pc_ena pulse).
  - FAULT: clear fetch_fault, pulse pc_ena, go to IDLE.
  - IDLE: pulse pc_ena, stay in IDLE one more cycle.
- Only one outstanding request at any time.
- pc_ena is registered; it is never high for two consecutive cycles.

Optional Feature:
- IFETCH_TIMEOUT_EN defined:
  - A TMO_W counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES without rvalid: go to FAULT, fetch_fault=1.
  - A late rvalid is then ignored.
- Undefined: no counter logic; WAIT is unbounded; TIMEOUT_CYCLES and TMO_W are unused.

Test Plan:
- Reset release, pc_in=0x00400000, imem_ready=1, rvalid one cycle later with rdata=0x20080005, ack when valid -> imem_addr=0x00400000, instr_out=0x20080005, single pc_ena pulse, next request issued 4 cycles after the previous one.
- imem_ready held low for 3 cycles -> imem_req and imem_addr stay stable for the whole 3 cycles; no pc_ena pulse.
- flush in WAIT, then rvalid with 0xDEADBEEF -> instr_valid stays 0; pc_ena pulses after rvalid; next fetch uses the new pc_in.
- pc_in=0x00400002 -> no imem_req; fetch_fault=1 held; a later flush clears it and fetching resumes.
- rst_n low while in HOLD -> instr_valid=0, instr_out=0, pc_ena=0 immediately (asynchronous); after release, a fresh fetch starts.
- With IFETCH_TIMEOUT_EN and TIMEOUT_CYCLES=64, rvalid withheld -> fetch_fault=1 at the 64th WAIT cycle; without the macro, no fault is raised after 200 cycles.
